// File: rtl/alu_operand_loader_if.sv
// Bus bundle between a chunk producer/consumer and the ALU operand loader.
// N and W of the interface instance must match those of the loader it feeds.
interface alu_operand_loader_if #(
  parameter int N = 32,
  parameter int W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  op_count;

  // Loader side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, a, b, op, out_valid, op_count
  );

  // Producer / ALU-stage side
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, a, b, op, out_valid, op_count
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Assembles an ALU operation from a stream of W-bit chunks:
// one opcode chunk, then K=N/W chunks of A, then K chunks of B (LS chunk first),
// and presents {a, b, op} with a valid/ready handshake.
module alu_operand_loader #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,   // asynchronous, active-low
  input  logic                clear,   // synchronous frame abort
  alu_operand_loader_if.slave bus
);

  localparam int K    = N / W;
  localparam int CW   = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  // Opcode needs at least 4 bits per chunk and operands must split evenly.
  generate
    if ((N % W) != 0 || W < 4) begin : g_param_check
      $error("alu_operand_loader: N must be a multiple of W and W >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {S_OP, S_A, S_B, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [15:0]   op_count_q, op_count_d;

  logic          in_ready;
  logic          xfer;
  logic [K-1:0]  chunk_sel;

  // One-hot select of the operand chunk addressed by the chunk counter.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_chunk_sel
      assign chunk_sel[gi] = (cnt_q == CW'(gi));
    end
  endgenerate

  // Ready is a pure state decode so there is no path from in_valid.
  assign in_ready = (state_q != S_OUT);
  assign xfer     = bus.in_valid && in_ready;

  // Next-state and datapath update; clear overrides transfers and handshakes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    op_count_d = op_count_q;

    if (clear) begin
      state_d = S_OP;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OP: begin
          if (xfer) begin
            op_d    = bus.in_data[3:0];
            cnt_d   = '0;
            state_d = S_A;
          end
        end
        S_A: begin
          if (xfer) begin
            for (int i = 0; i < K; i++) begin
              if (chunk_sel[i]) a_d[i*W +: W] = bus.in_data;
            end
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = S_B;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_B: begin
          if (xfer) begin
            for (int i = 0; i < K; i++) begin
              if (chunk_sel[i]) b_d[i*W +: W] = bus.in_data;
            end
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = S_OUT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            state_d    = S_OP;
            op_count_d = op_count_q + 16'd1;
          end
        end
        default: begin
          state_d = S_OP;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_OP;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.op        = op_q;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed + randomized bench for alu_operand_loader (N=32/W=8 and N=W=8).
module tb_alu_operand_loader;

  localparam int N = 32;
  localparam int W = 8;
  localparam int K = N / W;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic clear  = 1'b0;
  logic clear1 = 1'b0;

  always #5 clk = ~clk;

  alu_operand_loader_if #(.N(N), .W(W)) bus ();
  alu_operand_loader #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  alu_operand_loader_if #(.N(8), .W(8)) bus1 ();
  alu_operand_loader #(.N(8), .W(8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .clear (clear1),
    .bus   (bus1)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] exp_count   = 16'd0;   // reference count of completed operations

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one chunk (optionally after random idle cycles) until it is taken.
  task automatic push(input logic [W-1:0] d, input bit stall);
    int tries;
    if (stall) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tries = 0;
    while (bus.in_ready !== 1'b1 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 20) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Whole frame: opcode chunk (random upper bits), A then B, LS chunk first.
  task automatic send_frame(input logic [3:0] o, input logic [N-1:0] av,
                            input logic [N-1:0] bv, input bit stall);
    logic [W-1:0] c;
    c      = W'($urandom);
    c[3:0] = o;
    push(c, stall);
    for (int i = 0; i < K; i++) push(av[i*W +: W], stall);
    for (int i = 0; i < K; i++) push(bv[i*W +: W], stall);
  endtask

  // Hold out_ready low for 'hold' cycles (with junk input pulses), then take it.
  task automatic finish_frame(input logic [3:0] o, input logic [N-1:0] av,
                              input logic [N-1:0] bv, input int hold, input string tag);
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_a"}, 64'(bus.a), 64'(av));
      chk({tag, "_b"}, 64'(bus.b), 64'(bv));
      chk({tag, "_op"}, 64'(bus.op), 64'(o));
      chk({tag, "_in_ready_low"}, 64'(bus.in_ready), 64'd0);
      if (h < hold) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_data   = W'($urandom);
      end else begin
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    exp_count++;
    chk({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_op_count"}, 64'(bus.op_count), 64'(exp_count));
    chk({tag, "_in_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [3:0]   o;
    logic [N-1:0] av, bv;

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.out_ready = 1'b0;

    // Reset state, checked before any clock edge.
    #1;
    chk("rst_a", 64'(bus.a), 64'd0);
    chk("rst_b", 64'(bus.b), 64'd0);
    chk("rst_op", 64'(bus.op), 64'd0);
    chk("rst_op_count", 64'(bus.op_count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Basic frame, consumer always ready.
    send_frame(4'h2, 32'h12345678, 32'hDEADBEEF, 1'b0);
    finish_frame(4'h2, 32'h12345678, 32'hDEADBEEF, 0, "basic");

    // Backpressure: 5 cycles of out_ready=0, out_valid seen for 6 cycles.
    send_frame(4'h2, 32'h12345678, 32'hDEADBEEF, 1'b0);
    finish_frame(4'h2, 32'h12345678, 32'hDEADBEEF, 5, "bp");

    // Stalled stream with the basic frame, then random frames.
    send_frame(4'h2, 32'h12345678, 32'hDEADBEEF, 1'b1);
    finish_frame(4'h2, 32'h12345678, 32'hDEADBEEF, 0, "stall");
    for (int f = 0; f < 12; f++) begin
      o  = 4'($urandom);
      av = N'($urandom);
      bv = N'($urandom);
      send_frame(o, av, bv, 1'b1);
      finish_frame(o, av, bv, $urandom_range(0, 3), "rand");
    end

    // Clear after the 3rd A chunk, with a 4th A chunk offered in the same cycle.
    push(8'h07, 1'b0);
    for (int i = 0; i < 3; i++) push(8'h11, 1'b0);
    @(negedge clk);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAB;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("clr_in_ready", 64'(bus.in_ready), 64'd1);
    chk("clr_op_count", 64'(bus.op_count), 64'(exp_count));
    // Clear in idle with an opcode chunk offered: the chunk must be dropped.
    @(negedge clk);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0C;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    send_frame(4'h5, 32'h00000001, 32'h00000002, 1'b0);
    finish_frame(4'h5, 32'h00000001, 32'h00000002, 0, "clr_new");

    // Clear beats the output handshake: no count, outputs retained.
    send_frame(4'hA, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0);
    @(negedge clk);
    clear         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear         = 1'b0;
    bus.out_ready = 1'b0;
    chk("clr_out_drop", 64'(bus.out_valid), 64'd0);
    chk("clr_out_count", 64'(bus.op_count), 64'(exp_count));
    chk("clr_out_a_kept", 64'(bus.a), 64'h00000000CAFEF00D);
    chk("clr_out_op_kept", 64'(bus.op), 64'hA);

    // Asynchronous reset during B: outputs clear without a clock edge.
    push(8'h03, 1'b0);
    for (int i = 0; i < K; i++) push(8'h5A, 1'b0);
    for (int i = 0; i < 2; i++) push(8'hA5, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_count = 16'd0;
    chk("arst_a", 64'(bus.a), 64'd0);
    chk("arst_b", 64'(bus.b), 64'd0);
    chk("arst_op", 64'(bus.op), 64'd0);
    chk("arst_op_count", 64'(bus.op_count), 64'(exp_count));
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    send_frame(4'hC, 32'h89ABCDEF, 32'h01234567, 1'b1);
    finish_frame(4'hC, 32'h89ABCDEF, 32'h01234567, 1, "arst_next");

    // K=1 instance: one chunk each for opcode, A and B.
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'hF9;
    @(posedge clk);
    #1;
    bus1.in_data  = 8'h3C;
    @(posedge clk);
    #1;
    bus1.in_data  = 8'hA5;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    chk("k1_out_valid", 64'(bus1.out_valid), 64'd1);
    chk("k1_a", 64'(bus1.a), 64'h3C);
    chk("k1_b", 64'(bus1.b), 64'hA5);
    chk("k1_op", 64'(bus1.op), 64'h9);
    @(negedge clk);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b0;
    chk("k1_op_count", 64'(bus1.op_count), 64'd1);
    chk("k1_valid_drop", 64'(bus1.out_valid), 64'd0);

    // Counter wrap: preload 0xFFFF while idle, next completion reads 0.
    @(negedge clk);
    force dut.op_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.op_count_q;
    exp_count = 16'hFFFF;
    @(negedge clk);
    chk("wrap_preload", 64'(bus.op_count), 64'(exp_count));
    send_frame(4'h7, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);
    finish_frame(4'h7, 32'h0F0F0F0F, 32'hF0F0F0F0, 0, "wrap");
    chk("wrap_zero", 64'(bus.op_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
